// File: rtl/vend_txn_ctrl_pkg.sv
// Shared types and constants for the ticket vending transaction sequencer.
package vend_txn_ctrl_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned TICKET_W = 2;
   localparam int unsigned STATE_W  = 4;

   localparam logic [DATA_W-1:0] DEF_PRICE0 = 8'd20;
   localparam logic [DATA_W-1:0] DEF_PRICE1 = 8'd30;
   localparam logic [DATA_W-1:0] DEF_PRICE2 = 8'd50;
   localparam logic [DATA_W-1:0] DEF_PRICE3 = 8'd100;

   localparam int unsigned DEF_TIMEOUT_CYC = 1000;
   localparam int unsigned DEF_SUM_WDOG    = 15;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 4'd0,
      ST_CLEAR     = 4'd1,
      ST_WAIT_COIN = 4'd2,
      ST_ISSUE     = 4'd3,
      ST_WAIT_SUM  = 4'd4,
      ST_CHECK     = 4'd5,
      ST_DISPENSE  = 4'd6,
      ST_REFUND    = 4'd7,
      ST_FAULT     = 4'd8
   } state_t;

endpackage

// File: rtl/vend_txn_ctrl_timer.sv
// Up-counter cleared by load, saturating at TERMINAL; tc_c flags the terminal count.
module vend_timer #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned TERMINAL = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc_c
);

   logic [WIDTH-1:0] count;

   assign tc_c = (count >= WIDTH'(TERMINAL));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (en && !tc_c) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Ticket vending transaction sequencer: drives the sum_coins accumulator,
// compares the running total against the selected price, and issues dispense/refund.
module vend_txn_ctrl
   import vend_txn_ctrl_pkg::*;
#(
   parameter logic [DATA_W-1:0] PRICE0      = DEF_PRICE0,
   parameter logic [DATA_W-1:0] PRICE1      = DEF_PRICE1,
   parameter logic [DATA_W-1:0] PRICE2      = DEF_PRICE2,
   parameter logic [DATA_W-1:0] PRICE3      = DEF_PRICE3,
   parameter int unsigned       TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int unsigned       SUM_WDOG    = DEF_SUM_WDOG
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sel_valid,
   input  logic [TICKET_W-1:0] ticket_sel,
   input  logic                coin_valid,
   input  logic [DATA_W-1:0]   coin_value,
   output logic                coin_ready,
   output logic                coin_reject,
   input  logic                cancel,
   output logic                sum_frt_fg,
   output logic                sum_in_rdy,
   output logic [DATA_W-1:0]   sum_data,
   output logic                sum_out_rdy,
   input  logic [DATA_W-1:0]   sum_data_out,
   input  logic                sum_state_cmp,
   output logic                dispense,
   output logic [TICKET_W-1:0] ticket_id,
   output logic                change_valid,
   output logic [DATA_W-1:0]   change_amt,
   output logic                refund_valid,
   output logic [DATA_W-1:0]   refund_amt,
   output logic                busy,
   output logic                fault
);

   // Timeout terminal is one less than TIMEOUT_CYC so refund lands exactly TIMEOUT_CYC cycles after a coin.
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
   localparam int unsigned WD_W = $clog2(SUM_WDOG + 2);

   state_t              state, next_state;
   logic [DATA_W-1:0]   total_q, total_d;
   logic [DATA_W-1:0]   price_q, price_d;
   logic [TICKET_W-1:0] ticket_d;
   logic [DATA_W-1:0]   sum_data_d;
   logic                cancel_pend_q, cancel_pend_d;
   logic                coin_ready_d, coin_reject_d, sum_in_rdy_d;
   logic [DATA_W-1:0]   price_lut_c;
   logic [DATA_W:0]     coin_sum_c;
   logic                to_tc_c, wd_tc_c, to_load, wd_load, wd_en;

   assign coin_sum_c = {1'b0, total_q} + {1'b0, coin_value};

   always_comb begin
      case (ticket_sel)
         2'd0:    price_lut_c = PRICE0;
         2'd1:    price_lut_c = PRICE1;
         2'd2:    price_lut_c = PRICE2;
         default: price_lut_c = PRICE3;
      endcase
   end

   assign to_load = (state == ST_CLEAR) || ((state == ST_WAIT_COIN) && (next_state == ST_ISSUE));
   assign wd_load = (state == ST_ISSUE);
   assign wd_en   = (state == ST_WAIT_SUM);

   vend_timer #(.WIDTH(TO_W), .TERMINAL(TIMEOUT_CYC - 1)) u_timeout (
      .clk(clk), .rst(rst), .load(to_load), .en(1'b1), .tc_c(to_tc_c)
   );

   vend_timer #(.WIDTH(WD_W), .TERMINAL(SUM_WDOG + 1)) u_sum_wdog (
      .clk(clk), .rst(rst), .load(wd_load), .en(wd_en), .tc_c(wd_tc_c)
   );

   // Next-state and datapath decisions; registered outputs follow the chosen next state.
   always_comb begin
      next_state    = state;
      total_d       = total_q;
      price_d       = price_q;
      ticket_d      = ticket_id;
      sum_data_d    = sum_data;
      cancel_pend_d = cancel_pend_q;
      coin_ready_d  = 1'b0;
      coin_reject_d = 1'b0;
      sum_in_rdy_d  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (sel_valid) begin
               price_d    = price_lut_c;
               ticket_d   = ticket_sel;
               total_d    = '0;
               next_state = ST_CLEAR;
            end
         end
         ST_CLEAR: next_state = ST_WAIT_COIN;
         ST_WAIT_COIN: begin
            if (cancel) begin
               next_state = ST_REFUND;
            end else if (coin_valid && !coin_sum_c[DATA_W]) begin
               coin_ready_d = 1'b1;
               sum_data_d   = coin_value;
               next_state   = ST_ISSUE;
            end else if (to_tc_c) begin
               next_state = ST_REFUND;
            end else if (coin_valid) begin
               // Skip a cycle after each reject so a held coin yields distinct pulses.
               coin_reject_d = !coin_reject;
            end
         end
         ST_ISSUE: begin
            sum_in_rdy_d = 1'b1;
            next_state   = ST_WAIT_SUM;
         end
         ST_WAIT_SUM: begin
            total_d = sum_data_out;
            if (cancel) cancel_pend_d = 1'b1;
            if (sum_state_cmp) begin
               next_state = ST_CHECK;
            end else if (wd_tc_c) begin
               next_state = ST_FAULT;
            end
         end
         ST_CHECK: begin
            if (cancel_pend_q) begin
               next_state = ST_REFUND;
            end else if (total_q >= price_q) begin
               next_state = ST_DISPENSE;
            end else begin
               next_state = ST_WAIT_COIN;
            end
         end
         ST_DISPENSE: next_state = ST_IDLE;
         ST_REFUND: begin
            cancel_pend_d = 1'b0;
            next_state    = ST_IDLE;
         end
         ST_FAULT: next_state = ST_FAULT;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         total_q       <= '0;
         price_q       <= '0;
         cancel_pend_q <= 1'b0;
         ticket_id     <= '0;
         sum_data      <= '0;
         coin_ready    <= 1'b0;
         coin_reject   <= 1'b0;
         sum_frt_fg    <= 1'b0;
         sum_in_rdy    <= 1'b0;
         sum_out_rdy   <= 1'b0;
         dispense      <= 1'b0;
         change_valid  <= 1'b0;
         change_amt    <= '0;
         refund_valid  <= 1'b0;
         refund_amt    <= '0;
         busy          <= 1'b0;
         fault         <= 1'b0;
      end else begin
         state         <= next_state;
         total_q       <= total_d;
         price_q       <= price_d;
         cancel_pend_q <= cancel_pend_d;
         ticket_id     <= ticket_d;
         sum_data      <= sum_data_d;
         coin_ready    <= coin_ready_d;
         coin_reject   <= coin_reject_d;
         sum_in_rdy    <= sum_in_rdy_d;
         sum_frt_fg    <= (next_state == ST_CLEAR);
         sum_out_rdy   <= (next_state == ST_WAIT_SUM);
         dispense      <= (next_state == ST_DISPENSE);
         change_valid  <= (next_state == ST_DISPENSE);
         change_amt    <= (next_state == ST_DISPENSE) ? DATA_W'(total_q - price_q) : '0;
         refund_valid  <= (next_state == ST_REFUND);
         refund_amt    <= (next_state == ST_REFUND) ? total_q : '0;
         busy          <= (next_state != ST_IDLE);
         fault         <= (next_state == ST_FAULT);
      end
   end

endmodule
